// File: rtl/matrix_mult_seq_rect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_mult_seq_rect                                                       |
// | Sequential R x K by K x C matrix multiplier using one shared MAC per clock,|
// | with start/busy/done handshake, operand capture and accumulate mode.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module matrix_mult_seq_rect #(
   parameter int R      = 3,
   parameter int K      = 3,
   parameter int C      = 3,
   parameter int M      = 8,
   parameter int W      = 32,
   parameter bit SIGNED = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               acc_en,
   input  logic [M*R*K-1:0]   x,
   input  logic [M*K*C-1:0]   y,
   output logic [W*R*C-1:0]   o,
   output logic               busy,
   output logic               done
);

   localparam int IW  = (R > 1) ? $clog2(R) : 1;
   localparam int JW  = (C > 1) ? $clog2(C) : 1;
   localparam int KW  = (K > 1) ? $clog2(K) : 1;
   localparam int XIW = (M*R*K > 1) ? $clog2(M*R*K) : 1;
   localparam int YIW = (M*K*C > 1) ? $clog2(M*K*C) : 1;
   localparam int OIW = (W*R*C > 1) ? $clog2(W*R*C) : 1;

   localparam logic [IW-1:0] c_IMAX = IW'(R - 1);
   localparam logic [JW-1:0] c_JMAX = JW'(C - 1);
   localparam logic [KW-1:0] c_KMAX = KW'(K - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [IW-1:0]      r_i;
   logic [JW-1:0]      r_j;
   logic [KW-1:0]      r_k;
   logic [W-1:0]       r_acc;
   logic               r_acc_en;
   logic               r_done;
   logic [M*R*K-1:0]   r_x;
   logic [M*K*C-1:0]   r_y;
   logic [W*R*C-1:0]   r_o;

   logic [XIW-1:0]     w_xbase;
   logic [YIW-1:0]     w_ybase;
   logic [OIW-1:0]     w_obase;
   logic [M-1:0]       w_xel;
   logic [M-1:0]       w_yel;
   logic [W-1:0]       w_xe;
   logic [W-1:0]       w_ye;
   logic [W-1:0]       w_p;
   logic [W-1:0]       w_v;
   logic [W-1:0]       w_onew;
   logic               w_ilast;
   logic               w_jlast;
   logic               w_klast;
   logic               w_last;

   // Bit offsets of the current X, Y and O elements in their row-major buses
   always_comb begin
      w_xbase = XIW'(M * (K * int'(r_i) + int'(r_k)));
      w_ybase = YIW'(M * (C * int'(r_k) + int'(r_j)));
      w_obase = OIW'(W * (C * int'(r_i) + int'(r_j)));
   end

   assign w_xel = r_x[w_xbase +: M];
   assign w_yel = r_y[w_ybase +: M];

   generate
      if (SIGNED) begin : g_signed
         assign w_xe = W'($signed(w_xel));
         assign w_ye = W'($signed(w_yel));
      end else begin : g_unsigned
         assign w_xe = W'(w_xel);
         assign w_ye = W'(w_yel);
      end
   endgenerate

   assign w_p     = w_xe * w_ye;
   assign w_v     = r_acc + w_p;
   assign w_onew  = r_acc_en ? (r_o[w_obase +: W] + w_v) : w_v;

   assign w_ilast = (r_i == c_IMAX);
   assign w_jlast = (r_j == c_JMAX);
   assign w_klast = (r_k == c_KMAX);
   assign w_last  = w_ilast & w_jlast & w_klast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN);
      done = r_done;
      o    = r_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i      <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_acc    <= '0;
         r_acc_en <= 1'b0;
         r_done   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_o      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x      <= x;
                  r_y      <= y;
                  r_acc_en <= acc_en;
                  r_i      <= '0;
                  r_j      <= '0;
                  r_k      <= '0;
                  r_acc    <= '0;
               end
            end
            S_RUN: begin
               if (!w_klast) begin
                  r_acc <= w_v;
                  r_k   <= r_k + KW'(1);
               end else begin
                  // Final product of the dot product goes straight to O
                  r_o[w_obase +: W] <= w_onew;
                  r_acc             <= '0;
                  r_k               <= '0;
                  if (w_jlast) begin
                     r_j <= '0;
                     r_i <= w_ilast ? '0 : r_i + IW'(1);
                  end else begin
                     r_j <= r_j + JW'(1);
                  end
                  if (w_ilast && w_jlast) begin
                     r_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_seq_rect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_mult_seq_rect                                                    |
// | Bench for matrix_mult_seq_rect: unsigned 2x3x2 and signed 2x2x2 instances. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_matrix_mult_seq_rect;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;

   logic         a_start = 1'b0;
   logic         a_acc   = 1'b0;
   logic [47:0]  a_x     = '0;
   logic [47:0]  a_y     = '0;
   logic [127:0] a_o;
   logic         a_busy;
   logic         a_done;

   logic         b_start = 1'b0;
   logic         b_acc   = 1'b0;
   logic [31:0]  b_x     = '0;
   logic [31:0]  b_y     = '0;
   logic [127:0] b_o;
   logic         b_busy;
   logic         b_done;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   int DR [2] = '{2, 2};
   int DK [2] = '{3, 2};
   int DC [2] = '{2, 2};
   bit DS [2] = '{1'b0, 1'b1};

   logic [31:0] m_o   [2][6];
   logic [31:0] m_res [2][6];
   bit          m_busy[2];
   bit          m_done[2];
   bit          m_acc [2];
   int          m_cnt [2];

   always #5 clk = ~clk;

   matrix_mult_seq_rect #(.R(2), .K(3), .C(2), .M(8), .W(32), .SIGNED(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .acc_en(a_acc),
      .x(a_x), .y(a_y), .o(a_o), .busy(a_busy), .done(a_done)
   );

   matrix_mult_seq_rect #(.R(2), .K(2), .C(2), .M(8), .W(32), .SIGNED(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .acc_en(b_acc),
      .x(b_x), .y(b_y), .o(b_o), .busy(b_busy), .done(b_done)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint elem(input logic [47:0] v, input int idx, input bit s);
      logic [7:0] e;
      e = v[8*idx +: 8];
      if (s) return longint'($signed(e));
      return longint'({56'd0, e});
   endfunction

   // Reference: full product computed at acceptance, elements released on their schedule
   task automatic model_step(input int d, input bit st, input bit ae,
                             input logic [47:0] xv, input logic [47:0] yv);
      longint sum;
      int     e;
      m_done[d] = 1'b0;
      if (!m_busy[d]) begin
         if (st) begin
            for (int i = 0; i < DR[d]; i++) begin
               for (int j = 0; j < DC[d]; j++) begin
                  sum = 0;
                  for (int k = 0; k < DK[d]; k++)
                     sum += elem(xv, DK[d]*i + k, DS[d]) * elem(yv, DC[d]*k + j, DS[d]);
                  m_res[d][DC[d]*i + j] = 32'(sum);
               end
            end
            m_acc[d]  = ae;
            m_busy[d] = 1'b1;
            m_cnt[d]  = 0;
         end
      end else begin
         m_cnt[d]++;
         if (m_cnt[d] % DK[d] == 0) begin
            e = m_cnt[d] / DK[d] - 1;
            m_o[d][e] = m_acc[d] ? m_o[d][e] + m_res[d][e] : m_res[d][e];
         end
         if (m_cnt[d] == DR[d]*DC[d]*DK[d]) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 6; e++) m_o[d][e] = '0;
            m_busy[d] = 1'b0;
            m_done[d] = 1'b0;
            m_acc[d]  = 1'b0;
            m_cnt[d]  = 0;
         end
      end else begin
         model_step(0, a_start, a_acc, a_x, a_y);
         model_step(1, b_start, b_acc, {16'd0, b_x}, {16'd0, b_y});
      end
   end

   function automatic logic [127:0] exp_o(input int d);
      logic [127:0] v;
      v = '0;
      for (int e = 0; e < DR[d]*DC[d]; e++) v[32*e +: 32] = m_o[d][e];
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_o",    a_o,    exp_o(0));
         chk("a_busy", {127'd0, a_busy}, {127'd0, m_busy[0]});
         chk("a_done", {127'd0, a_done}, {127'd0, m_done[0]});
         chk("b_o",    b_o,    exp_o(1));
         chk("b_busy", {127'd0, b_busy}, {127'd0, m_busy[1]});
         chk("b_done", {127'd0, b_done}, {127'd0, m_done[1]});
      end
   end

   task automatic set_start(input int d, input bit v);
      if (d == 0) a_start = v; else b_start = v;
   endtask

   task automatic set_xy(input int d, input logic [47:0] xv, input logic [47:0] yv);
      if (d == 0) begin
         a_x = xv;
         a_y = yv;
      end else begin
         b_x = xv[31:0];
         b_y = yv[31:0];
      end
   endtask

   function automatic bit get_done(input int d);
      return (d == 0) ? a_done : b_done;
   endfunction

   function automatic logic [47:0] rnd48();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[47:0];
   endfunction

   // Starts a run and returns the start-edge-to-done latency in cycles (100 on timeout)
   task automatic run(input int d, input bit ae, input bit scramble, input int pulse_at,
                      input bit hold, output int lat);
      @(negedge clk);
      set_start(d, 1'b1);
      if (d == 0) a_acc = ae; else b_acc = ae;
      @(posedge clk);
      @(negedge clk);
      if (!hold) set_start(d, 1'b0);
      if (scramble) set_xy(d, rnd48(), rnd48());
      lat = 0;
      while (!get_done(d) && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == pulse_at) begin
            set_xy(d, rnd48(), rnd48());
            set_start(d, 1'b1);
         end else if (!hold) begin
            set_start(d, 1'b0);
         end
      end
   endtask

   int lat;

   initial begin
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk("reset_o",    a_o, 128'd0);
      chk("reset_busy", {127'd0, a_busy}, 128'd0);

      // Identity on the 2x2x2 instance, then accumulate with inputs changed after E0
      set_xy(1, {16'd0, 8'd1, 8'd0, 8'd0, 8'd1}, {16'd0, 8'd8, 8'd7, 8'd6, 8'd5});
      run(1, 1'b0, 1'b0, -1, 1'b0, lat);
      chk("ident_lat", 128'(lat), 128'd8);
      chk("ident_o", b_o, {32'd8, 32'd7, 32'd6, 32'd5});
      set_xy(1, {16'd0, 8'd1, 8'd0, 8'd0, 8'd1}, {16'd0, 8'd8, 8'd7, 8'd6, 8'd5});
      run(1, 1'b1, 1'b1, -1, 1'b0, lat);
      chk("accum_o", b_o, {32'd16, 32'd14, 32'd12, 32'd10});

      // Rectangular 2x3x2
      set_xy(0, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7});
      run(0, 1'b0, 1'b0, -1, 1'b0, lat);
      chk("rect_lat", 128'(lat), 128'd12);
      chk("rect_o", a_o, {32'd154, 32'd139, 32'd64, 32'd58});

      // Signed versus unsigned interpretation of 8'hFD * 8'h05
      set_xy(1, {40'd0, 8'hFD}, {40'd0, 8'h05});
      run(1, 1'b0, 1'b0, -1, 1'b0, lat);
      chk("signed_o", b_o, {96'd0, 32'hFFFF_FFF1});
      set_xy(0, {40'd0, 8'hFD}, {40'd0, 8'h05});
      run(0, 1'b0, 1'b0, -1, 1'b0, lat);
      chk("unsigned_o", a_o, {96'd0, 32'd1265});

      // Start pulse while busy is ignored
      set_xy(0, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7});
      run(0, 1'b0, 1'b0, 3, 1'b0, lat);
      chk("busy_start_lat", 128'(lat), 128'd12);
      chk("busy_start_o", a_o, {32'd154, 32'd139, 32'd64, 32'd58});

      // Start held across done restarts immediately
      run(0, 1'b0, 1'b0, -1, 1'b1, lat);
      chk("hold_lat", 128'(lat), 128'd12);
      @(negedge clk);
      set_start(0, 1'b0);
      chk("hold_restart", {127'd0, a_busy}, 128'd1);
      lat = 0;
      while (!a_done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("hold_second_done", {127'd0, a_done}, 128'd1);

      // Asynchronous reset in the middle of a run
      set_xy(0, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7});
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_o",    a_o, 128'd0);
      chk("rst_async_busy", {127'd0, a_busy}, 128'd0);
      chk("rst_async_done", {127'd0, a_done}, 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(0, 1'b0, 1'b0, -1, 1'b0, lat);
      chk("post_rst_lat", 128'(lat), 128'd12);
      chk("post_rst_o", a_o, {32'd154, 32'd139, 32'd64, 32'd58});

      // Randomized runs on both instances
      for (int n = 0; n < 24; n++) begin
         int d;
         d = n % 2;
         set_xy(d, rnd48(), rnd48());
         run(d, 1'(($urandom % 2)), 1'(($urandom % 2)), (n % 3 == 0) ? 2 : -1, 1'b0, lat);
         chk("rand_lat", 128'(lat), 128'(DR[d]*DC[d]*DK[d]));
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
